// File: rtl/boot_monitor.sv
// boot_monitor: UART host loader that writes/reads cpu RAM and starts the cpu.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   rx_byte, received              UART receive byte and its one-cycle strobe
//   tx_byte, transmit              byte to send and its one-cycle strobe
//   is_transmitting                UART busy flag
//   ram_waddr, ram_wdata, ram_we   RAM write port
//   ram_raddr, ram_rdata           RAM read port (registered, 1-cycle latency)
//   cpu_start, cpu_startaddr       cpu launch pulse and entry address
//   cpu_run                        cpu owns RAM and UART while high
//   cpu_halted                     cpu HLT pulse
module boot_monitor #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  received,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    input  logic                  is_transmitting,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [7:0]            ram_rdata,
    output logic                  cpu_start,
    output logic [ADDR_WIDTH-1:0] cpu_startaddr,
    output logic                  cpu_run,
    input  logic                  cpu_halted
);
    typedef enum logic [3:0] {IDLE, ADDRH, ADDRL, LEN, DATA, RDWAIT, RDCAP, TX, RUN} state_t;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_G = 8'h47;
    state_t state, state_n;
    logic [7:0] cmd, ahi;
    logic [ADDR_WIDTH-1:0] addr;
    logic [8:0] count;
    logic [15:0] full_addr;
    logic [ADDR_WIDTH-1:0] new_addr;
    logic known;
    assign full_addr = {ahi, rx_byte};
    assign new_addr = full_addr[ADDR_WIDTH-1:0];
    assign known = rx_byte == CMD_W || rx_byte == CMD_R || rx_byte == CMD_G;
    always_comb begin
        state_n = state;
        transmit = 1'b0;
        case (state)
            IDLE:    if (received) state_n = known ? ADDRH : TX;
            ADDRH:   if (received) state_n = ADDRL;
            ADDRL:   if (received) state_n = cmd == CMD_W ? LEN : cmd == CMD_R ? RDWAIT : RUN;
            LEN:     if (received) state_n = DATA;
            DATA:    if (received && count == 9'd1) state_n = TX;
            RDWAIT:  state_n = RDCAP;
            RDCAP:   state_n = TX;
            TX: begin
                // Strobe is combinational so it can never overlap a busy UART.
                transmit = !is_transmitting && !rst;
                if (!is_transmitting) state_n = IDLE;
            end
            RUN:     if (cpu_halted) state_n = TX;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd <= '0;
            ahi <= '0;
            addr <= '0;
            count <= '0;
            tx_byte <= '0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_we <= 1'b0;
            ram_raddr <= '0;
            cpu_start <= 1'b0;
            cpu_startaddr <= '0;
            cpu_run <= 1'b0;
        end else begin
            state <= state_n;
            ram_we <= state == DATA && received;
            cpu_start <= state == ADDRL && received && cmd == CMD_G;
            case (state)
                IDLE: if (received) begin
                    cmd <= rx_byte;
                    if (!known) tx_byte <= 8'h3F;
                end
                ADDRH: if (received) ahi <= rx_byte;
                ADDRL: if (received) begin
                    addr <= new_addr;
                    if (cmd == CMD_R) ram_raddr <= new_addr;
                    if (cmd == CMD_G) begin
                        cpu_startaddr <= new_addr;
                        cpu_run <= 1'b1;
                    end
                end
                // A length byte of zero stands for a full 256-byte block.
                LEN: if (received) count <= rx_byte == 8'd0 ? 9'd256 : {1'b0, rx_byte};
                DATA: if (received) begin
                    ram_waddr <= addr;
                    ram_wdata <= rx_byte;
                    addr <= addr + 1'b1;
                    count <= count - 9'd1;
                    if (count == 9'd1) tx_byte <= 8'h2E;
                end
                RDCAP: tx_byte <= ram_rdata;
                RUN: if (cpu_halted) begin
                    cpu_run <= 1'b0;
                    tx_byte <= 8'h21;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_monitor.sv
// tb_boot_monitor: vector table, corner sequences and random commands against a command-level model.
module tb_boot_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rx_byte = '0;
    logic received = 1'b0;
    logic [7:0] tx_byte;
    logic transmit;
    logic is_transmitting = 1'b0;
    logic [8:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic ram_we;
    logic [8:0] ram_raddr;
    logic [7:0] ram_rdata;
    logic cpu_start;
    logic [8:0] cpu_startaddr;
    logic cpu_run;
    logic cpu_halted = 1'b0;

    boot_monitor #(.ADDR_WIDTH(9)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received),
        .tx_byte(tx_byte), .transmit(transmit), .is_transmitting(is_transmitting),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .cpu_start(cpu_start), .cpu_startaddr(cpu_startaddr), .cpu_run(cpu_run),
        .cpu_halted(cpu_halted)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [512];
    always @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        ram_rdata <= ram[ram_raddr];
    end

    int checks = 0;
    int failures = 0;
    logic [7:0] txlog[$];
    logic [16:0] wlog[$];
    logic [16:0] ew[$];
    logic [7:0] mm [512];
    bit mv [512];
    int start_cnt = 0;
    logic [8:0] start_addr = '0;
    bit rnd_busy = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (transmit) begin
            txlog.push_back(tx_byte);
            chk("tx_while_busy", 64'(is_transmitting), 64'd0);
        end
        if (ram_we) wlog.push_back({ram_waddr, ram_wdata});
        if (cpu_start) begin
            start_cnt++;
            start_addr = cpu_startaddr;
        end
        if (cpu_run) chk("cpu_run_exclusive", 64'(ram_we | transmit), 64'd0);
    end

    // Command-level model: what writes and which reply byte a complete command yields.
    function automatic logic [7:0] model(input logic [7:0] c[$]);
        int a, n;
        if (c[0] != 8'h57 && c[0] != 8'h52) return 8'h3F;
        a = int'({c[1], c[2]}) % 512;
        if (c[0] == 8'h52) return mm[a];
        n = (c[3] == 8'd0) ? 256 : int'(c[3]);
        for (int i = 0; i < n; i++) begin
            ew.push_back({9'((a + i) % 512), c[4 + i]});
            mm[(a + i) % 512] = c[4 + i];
            mv[(a + i) % 512] = 1;
        end
        return 8'h2E;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b;
        received = 1'b1;
        tick();
        received = 1'b0;
        tick();
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 300 && txlog.size() == 0; i++) begin
            if (rnd_busy) is_transmitting = 1'($urandom_range(0, 1));
            tick();
        end
        is_transmitting = 1'b0;
        repeat (2) tick();
    endtask

    task automatic clear_logs();
        txlog = {};
        wlog = {};
        ew = {};
    endtask

    task automatic run_cmd(input logic [7:0] c[$]);
        logic [7:0] etx;
        clear_logs();
        etx = model(c);
        for (int i = 0; i < c.size() - 1; i++) send(c[i]);
        chk("early_tx", 64'(txlog.size()), 64'd0);
        send(c[c.size() - 1]);
        wait_tx();
        chk("tx_count", 64'(txlog.size()), 64'd1);
        if (txlog.size() > 0) chk("tx_byte", 64'(txlog[0]), 64'(etx));
        chk("we_count", 64'(wlog.size()), 64'(ew.size()));
        for (int i = 0; i < wlog.size() && i < ew.size(); i++) chk("write", 64'(wlog[i]), 64'(ew[i]));
    endtask

    typedef struct {
        int n;
        logic [63:0] b;
        logic [7:0] tx;
        int nw;
        logic [8:0] wa;
    } vec_t;

    initial begin
        vec_t vecs [9];
        logic [7:0] c[$];
        int a;
        vecs[0] = '{7, {8'h57, 8'h00, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00}, 8'h2E, 3, 9'h010};
        vecs[1] = '{6, {8'h57, 8'h01, 8'hFF, 8'h02, 8'h11, 8'h22, 16'h0}, 8'h2E, 2, 9'h1FF};
        vecs[2] = '{5, {8'h57, 8'h00, 8'h20, 8'h01, 8'h5A, 24'h0}, 8'h2E, 1, 9'h020};
        vecs[3] = '{3, {8'h52, 8'h00, 8'h20, 40'h0}, 8'h5A, 0, 9'h0};
        vecs[4] = '{3, {8'h52, 8'h00, 8'h11, 40'h0}, 8'hBB, 0, 9'h0};
        vecs[5] = '{3, {8'h52, 8'hFE, 8'h11, 40'h0}, 8'hBB, 0, 9'h0};
        vecs[6] = '{3, {8'h52, 8'h02, 8'h00, 40'h0}, 8'h22, 0, 9'h0};
        vecs[7] = '{1, {8'h99, 56'h0}, 8'h3F, 0, 9'h0};
        vecs[8] = '{1, {8'h00, 56'h0}, 8'h3F, 0, 9'h0};

        repeat (3) tick();
        chk("reset_outputs", 64'({tx_byte, transmit, ram_waddr, ram_wdata, ram_we, ram_raddr,
            cpu_start, cpu_startaddr, cpu_run}), 64'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            c = {};
            for (int i = 0; i < vecs[v].n; i++) c.push_back(vecs[v].b[63 - 8 * i -: 8]);
            run_cmd(c);
            if (txlog.size() > 0) chk($sformatf("vec%0d_tx", v), 64'(txlog[0]), 64'(vecs[v].tx));
            chk($sformatf("vec%0d_nw", v), 64'(wlog.size()), 64'(vecs[v].nw));
            if (vecs[v].nw > 0 && wlog.size() > 0) chk($sformatf("vec%0d_wa", v), 64'(wlog[0][16:8]), 64'(vecs[v].wa));
        end

        // Run, ignored traffic during RUN, halt reply.
        clear_logs();
        start_cnt = 0;
        send(8'h47); send(8'h00); send(8'h05);
        chk("start_pulses", 64'(start_cnt), 64'd1);
        chk("start_addr", 64'(start_addr), 64'h005);
        chk("cpu_run_on", 64'(cpu_run), 64'd1);
        send(8'h57); send(8'h00); send(8'h00); send(8'h01); send(8'hAA); send(8'h99);
        chk("run_no_writes", 64'(wlog.size()), 64'd0);
        chk("run_no_tx", 64'(txlog.size()), 64'd0);
        chk("run_still", 64'(cpu_run), 64'd1);
        chk("startaddr_held", 64'(cpu_startaddr), 64'h005);
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
        chk("cpu_run_off", 64'(cpu_run), 64'd0);
        wait_tx();
        chk("halt_tx_count", 64'(txlog.size()), 64'd1);
        if (txlog.size() > 0) chk("halt_tx", 64'(txlog[0]), 64'h21);
        chk("start_pulses_total", 64'(start_cnt), 64'd1);

        // cpu_halted in IDLE is ignored.
        clear_logs();
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
        repeat (10) tick();
        chk("idle_halt_ignored", 64'(txlog.size()), 64'd0);

        // Busy UART holds off the '?' reply.
        clear_logs();
        is_transmitting = 1'b1;
        send(8'h99);
        repeat (50) tick();
        chk("busy_no_tx", 64'(txlog.size()), 64'd0);
        is_transmitting = 1'b0;
        wait_tx();
        chk("busy_tx_count", 64'(txlog.size()), 64'd1);
        if (txlog.size() > 0) chk("busy_tx", 64'(txlog[0]), 64'h3F);

        // len=0 means a 256-byte block.
        c = {8'h57, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) c.push_back(8'(i * 7 + 3));
        run_cmd(c);
        if (wlog.size() == 256) chk("len0_last_addr", 64'(wlog[255][16:8]), 64'h0FF);

        // Reset part-way through DATA, with a byte strobed in the same cycle.
        clear_logs();
        send(8'h57); send(8'h00); send(8'h40); send(8'h05);
        send(8'h01); send(8'h02); send(8'h03);
        rx_byte = 8'h04;
        received = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        received = 1'b0;
        chk("rst_mid_outputs", 64'({tx_byte, transmit, ram_waddr, ram_wdata, ram_we, ram_raddr,
            cpu_start, cpu_startaddr, cpu_run}), 64'd0);
        repeat (5) tick();
        chk("rst_mid_writes", 64'(wlog.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            mm[64 + i] = 8'(i + 1);
            mv[64 + i] = 1;
        end
        run_cmd({8'h52, 8'h00, 8'h42});

        // Reset during RUN beats a same-cycle halt; no '!' follows.
        clear_logs();
        send(8'h47); send(8'h01); send(8'h23);
        chk("run2_on", 64'(cpu_run), 64'd1);
        cpu_halted = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_halted = 1'b0;
        chk("rst_run_off", 64'(cpu_run), 64'd0);
        repeat (10) tick();
        chk("rst_run_no_tx", 64'(txlog.size()), 64'd0);

        // Random commands with a randomly busy UART.
        rnd_busy = 1;
        for (int k = 0; k < 40; k++) begin
            c = {};
            case ($urandom_range(0, 2))
                0: begin
                    c = {8'h57, 8'($urandom), 8'($urandom), 8'($urandom_range(1, 4))};
                    for (int i = 0; i < int'(c[3]); i++) c.push_back(8'($urandom));
                end
                1: begin
                    do a = $urandom_range(0, 511); while (!mv[a]);
                    c = {8'h52, {7'($urandom), 1'(a >> 8)}, 8'(a)};
                end
                default: begin
                    logic [7:0] x;
                    do x = 8'($urandom); while (x == 8'h57 || x == 8'h52 || x == 8'h47);
                    c = {x};
                end
            endcase
            run_cmd(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
